stopwatch_lap_timer: RTL and testbench
======================================

STOPWATCH_LAP_TIMER -- requirements
Module: stopwatch_lap_timer

Interface
REQ-001 Parameter FRAC_MAX, default 10000, ticks per second (sub-second counter modulus).
REQ-002 Parameter FRAC_W, default 14, width of sub-second fields; SHALL satisfy 2^FRAC_W >= FRAC_MAX.
REQ-003 Parameter MIN_MAX, default 60, minute counter modulus.
REQ-004 Parameter WRAP, default 0, up-count overflow behaviour: 1 = roll over, 0 = stop and flag done.
REQ-005 Parameter LAP_W, default 4, width of lap counter.
REQ-006 clk_10000Hz  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse: begin/resume counting.
REQ-009 stop  in  1  one-cycle pulse: pause counting.
REQ-010 clear  in  1  zero time, laps, state.
REQ-011 load  in  1  load preset_min:preset_sec:0, enter PAUSE.
REQ-012 count_down  in  1  direction: 0 up, 1 down; sampled every cycle.
REQ-013 preset_sec  in  6  seconds preset, 0..59.
REQ-014 preset_min  in  7  minutes preset, 0..MIN_MAX-1.
REQ-015 lap  in  1  one-cycle pulse: capture current time.
REQ-016 frac_out  out  FRAC_W  sub-second count.
REQ-017 sec_out  out  6  seconds 0..59.
REQ-018 min_out  out  7  minutes 0..MIN_MAX-1.
REQ-019 running  out  1  high in RUN state.
REQ-020 done  out  1  one-cycle pulse on terminal event.
REQ-021 lap_frac, lap_sec, lap_min  out  FRAC_W/6/7  last captured time.
REQ-022 lap_valid  out  1  one-cycle pulse when lap registers update.
REQ-023 lap_count  out  LAP_W  number of laps captured, saturating.

Function
REQ-024 States: IDLE (time zero, never started), RUN, PAUSE, DONE.
REQ-025 Command priority each cycle: reset > clear > load > stop > start > lap; lower-priority commands in the same cycle are ignored except lap (REQ-032).
REQ-026 IDLE/PAUSE + start -> RUN next cycle; RUN + stop -> PAUSE; start and stop together -> stop wins; DONE ignores start/stop.
REQ-027 RUN, up: frac increments each cycle; at FRAC_MAX-1 -> 0 with sec+1; sec 59 -> 0 with min+1.
REQ-028 Up at MIN_MAX-1:59:FRAC_MAX-1: WRAP=1 -> next value 0:0:0, stays RUN, done pulses; WRAP=0 -> value holds, state DONE, done pulses.
REQ-029 RUN, down: frac decrements; 0 -> FRAC_MAX-1 with sec-1; sec 0 -> 59 with min-1.
REQ-030 Down reaching 0:0:0: the cycle the value becomes 0:0:0, state -> DONE, done pulses same cycle as value update; start in RUN/PAUSE at 0:0:0 with count_down=1 -> DONE immediately, done pulses, value unchanged.
REQ-031 Direction change mid-run takes effect on the next increment/decrement; no skipped or repeated value.
REQ-032 lap in RUN, PAUSE or DONE: lap_* registers take the time value present at outputs in that cycle (pre-update), lap_valid pulses next cycle with them, lap_count+1 saturating at 2^LAP_W-1; lap in IDLE ignored; lap with clear or load ignored.
REQ-033 clear: time 0:0:0, lap_* 0, lap_count 0, state IDLE, done/lap_valid 0, next cycle.
REQ-034 load: time preset_min:preset_sec:0, state PAUSE; out-of-range preset clamps (sec>59 -> 59, min>=MIN_MAX -> MIN_MAX-1); lap registers unchanged.
REQ-035 All outputs registered; a command in cycle N visible on outputs at cycle N+1; counting latency one cycle per tick.
REQ-036 done and lap_valid never high more than one consecutive cycle.

Reset
REQ-037 reset high at a rising edge: all outputs 0, state IDLE; applies from any state, including mid-count and same cycle as any command.
REQ-038 Counter values never leave legal range under any input sequence.

Verification (FRAC_MAX=10, MIN_MAX=2 unless stated)
REQ-039 reset, start, 25 cycles -> frac=5, sec=2, min=0, running=1; stop -> value frozen, running=0.
REQ-040 WRAP=0, start, run 1200 cycles -> 1:59:9, DONE, one done pulse; further start ignored.
REQ-041 WRAP=1, run 1200 cycles -> 0:0:0, done pulse, running stays 1, counting continues.
REQ-042 load 0:1, count_down=1, start, 10 cycles -> 0:0:0, done pulse, DONE; clear -> IDLE, zeros.
REQ-043 RUN at 0:0:7, lap -> lap=0:0:7, lap_valid one cycle, lap_count=1; lap 16 more times with LAP_W=4 -> lap_count=15.
REQ-044 start and stop same cycle from PAUSE -> stays PAUSE; reset asserted mid-run with lap -> all zero, no lap_valid.

Source files
------------

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch / lap timer: min:sec:frac time counter with up/down counting, preset load,
// terminal-event detection and lap capture. All outputs come straight from registers.
module stopwatch_lap_timer #(
  parameter int unsigned FRAC_MAX = 10000,
  parameter int unsigned FRAC_W   = 14,
  parameter int unsigned MIN_MAX  = 60,
  parameter bit          WRAP     = 1'b0,
  parameter int unsigned LAP_W    = 4
) (
  input  logic              clk_10000Hz,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              load,
  input  logic              count_down,
  input  logic [5:0]        preset_sec,
  input  logic [6:0]        preset_min,
  input  logic              lap,
  output logic [FRAC_W-1:0] frac_out,
  output logic [5:0]        sec_out,
  output logic [6:0]        min_out,
  output logic              running,
  output logic              done,
  output logic [FRAC_W-1:0] lap_frac,
  output logic [5:0]        lap_sec,
  output logic [6:0]        lap_min,
  output logic              lap_valid,
  output logic [LAP_W-1:0]  lap_count
);

  localparam logic [FRAC_W-1:0] FracLast = FRAC_W'(FRAC_MAX - 1);
  localparam logic [5:0]        SecLast  = 6'd59;
  localparam logic [6:0]        MinLast  = 7'(MIN_MAX - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e             state_q, state_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [5:0]         sec_q, sec_d;
  logic [6:0]         min_q, min_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic [FRAC_W-1:0]  lap_frac_q, lap_frac_d;
  logic [5:0]         lap_sec_q, lap_sec_d;
  logic [6:0]         lap_min_q, lap_min_d;
  logic               lap_valid_q, lap_valid_d;
  logic [LAP_W-1:0]   lap_count_q, lap_count_d;

  logic [FRAC_W-1:0]  frac_inc, frac_dec;
  logic [5:0]         sec_inc, sec_dec, sec_clamp;
  logic [6:0]         min_inc, min_dec, min_clamp;
  logic               at_max, at_zero, at_one, lap_ok;

  assign at_max  = (frac_q == FracLast) && (sec_q == SecLast) && (min_q == MinLast);
  assign at_zero = (frac_q == '0) && (sec_q == '0) && (min_q == '0);
  assign at_one  = (frac_q == FRAC_W'(1)) && (sec_q == '0) && (min_q == '0);

  assign sec_clamp = (preset_sec > SecLast) ? SecLast : preset_sec;
  assign min_clamp = (32'(preset_min) >= MIN_MAX) ? MinLast : preset_min;

  // Back-to-back laps are dropped so lap_valid can never stay high for two cycles.
  assign lap_ok = lap && (state_q != StIdle) && !lap_valid_q;

  // One tick forward; at the maximum this naturally rolls to 0:0:0.
  always_comb begin
    frac_inc = frac_q + FRAC_W'(1);
    sec_inc  = sec_q;
    min_inc  = min_q;
    if (frac_q == FracLast) begin
      frac_inc = '0;
      if (sec_q == SecLast) begin
        sec_inc = '0;
        min_inc = (min_q == MinLast) ? '0 : min_q + 7'd1;
      end else begin
        sec_inc = sec_q + 6'd1;
      end
    end
  end

  // One tick backward; only used when the time is non-zero.
  always_comb begin
    frac_dec = frac_q - FRAC_W'(1);
    sec_dec  = sec_q;
    min_dec  = min_q;
    if (frac_q == '0) begin
      frac_dec = FracLast;
      if (sec_q == '0) begin
        sec_dec = SecLast;
        min_dec = min_q - 7'd1;
      end else begin
        sec_dec = sec_q - 6'd1;
      end
    end
  end

  // Command decode, state transitions and counting, in command-priority order.
  always_comb begin
    state_d     = state_q;
    frac_d      = frac_q;
    sec_d       = sec_q;
    min_d       = min_q;
    done_d      = 1'b0;
    lap_frac_d  = lap_frac_q;
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_valid_d = 1'b0;
    lap_count_d = lap_count_q;

    if (clear) begin
      state_d     = StIdle;
      frac_d      = '0;
      sec_d       = '0;
      min_d       = '0;
      lap_frac_d  = '0;
      lap_sec_d   = '0;
      lap_min_d   = '0;
      lap_count_d = '0;
    end else if (load) begin
      state_d = StPause;
      frac_d  = '0;
      sec_d   = sec_clamp;
      min_d   = min_clamp;
    end else begin
      // Lap captures the pre-update time and coexists with start/stop/counting.
      if (lap_ok) begin
        lap_frac_d  = frac_q;
        lap_sec_d   = sec_q;
        lap_min_d   = min_q;
        lap_valid_d = 1'b1;
        if (lap_count_q != '1) begin
          lap_count_d = lap_count_q + LAP_W'(1);
        end
      end

      if (stop) begin
        if (state_q == StRun) begin
          state_d = StPause;
        end
      end else if (start && (state_q == StIdle || state_q == StPause)) begin
        // Resuming a down-count that has nothing left to count ends immediately.
        if (count_down && at_zero && state_q == StPause) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StRun;
        end
      end else if (state_q == StRun) begin
        if (count_down) begin
          if (at_zero) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            frac_d = frac_dec;
            sec_d  = sec_dec;
            min_d  = min_dec;
            if (at_one) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end else if (at_max && !WRAP) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          frac_d = frac_inc;
          sec_d  = sec_inc;
          min_d  = min_inc;
          done_d = at_max;
        end
      end
    end
  end

  assign running_d = (state_d == StRun);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_10000Hz) begin
    if (reset) begin
      state_q     <= StIdle;
      frac_q      <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      lap_frac_q  <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_valid_q <= 1'b0;
      lap_count_q <= '0;
    end else begin
      state_q     <= state_d;
      frac_q      <= frac_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      running_q   <= running_d;
      done_q      <= done_d;
      lap_frac_q  <= lap_frac_d;
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_valid_q <= lap_valid_d;
      lap_count_q <= lap_count_d;
    end
  end

  assign frac_out  = frac_q;
  assign sec_out   = sec_q;
  assign min_out   = min_q;
  assign running   = running_q;
  assign done      = done_q;
  assign lap_frac  = lap_frac_q;
  assign lap_sec   = lap_sec_q;
  assign lap_min   = lap_min_q;
  assign lap_valid = lap_valid_q;
  assign lap_count = lap_count_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer: two instances (WRAP=0 and WRAP=1) share stimulus; a
// tick-count reference model predicts each cycle and a monitor checks the scoreboard queues.
module tb_stopwatch_lap_timer;

  localparam int FM   = 10;
  localparam int MM   = 2;
  localparam int FW   = 4;
  localparam int LW   = 4;
  localparam int TMAX = MM * 60 * FM - 1;
  localparam int LMAX = (1 << LW) - 1;

  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;

  typedef struct packed {
    int t;
    bit running;
    bit done;
    bit lv;
    int lt;
    int lc;
  } exp_s;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, lap = 1'b0;
  logic count_down = 1'b0;
  logic [5:0] preset_sec = '0;
  logic [6:0] preset_min = '0;

  logic [FW-1:0] frac0, frac1, lfrac0, lfrac1;
  logic [5:0]    sec0, sec1, lsec0, lsec1;
  logic [6:0]    min0, min1, lmin0, lmin1;
  logic          run0, run1, done0, done1, lv0, lv1;
  logic [LW-1:0] lc0, lc1;

  int checks = 0;
  int failures = 0;
  bit dir = 1'b0;

  int m_t[2], m_st[2], m_lt[2], m_lc[2];
  bit m_done[2], m_lv[2];

  exp_s exp_q0[$], exp_q1[$];
  int   lapq0[$], lapq1[$];
  exp_s e0, e1;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(.FRAC_MAX(FM), .FRAC_W(FW), .MIN_MAX(MM), .WRAP(1'b0), .LAP_W(LW)) u_w0 (
    .clk_10000Hz(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
    .count_down(count_down), .preset_sec(preset_sec), .preset_min(preset_min), .lap(lap),
    .frac_out(frac0), .sec_out(sec0), .min_out(min0), .running(run0), .done(done0),
    .lap_frac(lfrac0), .lap_sec(lsec0), .lap_min(lmin0), .lap_valid(lv0), .lap_count(lc0)
  );

  stopwatch_lap_timer #(.FRAC_MAX(FM), .FRAC_W(FW), .MIN_MAX(MM), .WRAP(1'b1), .LAP_W(LW)) u_w1 (
    .clk_10000Hz(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
    .count_down(count_down), .preset_sec(preset_sec), .preset_min(preset_min), .lap(lap),
    .frac_out(frac1), .sec_out(sec1), .min_out(min1), .running(run1), .done(done1),
    .lap_frac(lfrac1), .lap_sec(lsec1), .lap_min(lmin1), .lap_valid(lv1), .lap_count(lc1)
  );

  function automatic int enc(input int mn, input int sc, input int fr);
    return mn * 10000 + sc * 100 + fr;
  endfunction

  // Time as a single tick count, rendered back as min:sec:frac for comparison.
  function automatic int enc_t(input int t);
    return enc(t / (60 * FM), (t / FM) % 60, t % FM);
  endfunction

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, expv, $time);
    end
  endtask

  // Reference model: time is one integer tick count; one call per clock edge.
  task automatic model_step(input int k, input bit wrapm, input bit r, input bit cl,
                            input bit ld, input bit sp, input bit st, input bit lp,
                            input bit dn, input int ps, input int pm);
    int   pre_t;
    bit   pre_lv;
    exp_s e;
    pre_t  = m_t[k];
    pre_lv = m_lv[k];
    m_done[k] = 1'b0;
    m_lv[k]   = 1'b0;
    if (r) begin
      m_t[k] = 0; m_st[k] = MIdle; m_lt[k] = 0; m_lc[k] = 0;
    end else if (cl) begin
      m_t[k] = 0; m_st[k] = MIdle; m_lt[k] = 0; m_lc[k] = 0;
    end else if (ld) begin
      m_t[k]  = ((pm >= MM ? MM - 1 : pm) * 60 + (ps > 59 ? 59 : ps)) * FM;
      m_st[k] = MPause;
    end else begin
      if (lp && m_st[k] != MIdle && !pre_lv) begin
        m_lt[k] = pre_t;
        m_lv[k] = 1'b1;
        m_lc[k] = (m_lc[k] < LMAX) ? m_lc[k] + 1 : LMAX;
        if (k == 0) lapq0.push_back(pre_t);
        else lapq1.push_back(pre_t);
      end
      if (sp) begin
        if (m_st[k] == MRun) m_st[k] = MPause;
      end else if (st && (m_st[k] == MIdle || m_st[k] == MPause)) begin
        if (dn && m_t[k] == 0 && m_st[k] == MPause) begin
          m_st[k] = MDone; m_done[k] = 1'b1;
        end else begin
          m_st[k] = MRun;
        end
      end else if (m_st[k] == MRun) begin
        if (dn) begin
          if (m_t[k] > 0) m_t[k] = m_t[k] - 1;
          if (m_t[k] == 0) begin
            m_st[k] = MDone; m_done[k] = 1'b1;
          end
        end else if (m_t[k] == TMAX) begin
          m_done[k] = 1'b1;
          if (wrapm) m_t[k] = 0;
          else m_st[k] = MDone;
        end else begin
          m_t[k] = m_t[k] + 1;
        end
      end
    end
    e.t = m_t[k]; e.running = (m_st[k] == MRun); e.done = m_done[k];
    e.lv = m_lv[k]; e.lt = m_lt[k]; e.lc = m_lc[k];
    if (k == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and record the prediction.
  task automatic cyc(input bit r, input bit cl, input bit ld, input bit sp, input bit st,
                     input bit lp, input bit dn, input int ps, input int pm);
    @(negedge clk);
    reset = r; clear = cl; load = ld; stop = sp; start = st; lap = lp; count_down = dn;
    preset_sec = 6'(ps); preset_min = 7'(pm);
    dir = dn;
    for (int k = 0; k < 2; k++) model_step(k, k == 1, r, cl, ld, sp, st, lp, dn, ps & 63, pm & 127);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, dir, 0, 0);
  endtask

  task automatic check_inst(input string tag, input exp_s e, input int tm, input int rn,
                            input int dn, input int lv, input int lt, input int lc);
    chk({tag, " time"}, tm, enc_t(e.t));
    chk({tag, " running"}, rn, int'(e.running));
    chk({tag, " done"}, dn, int'(e.done));
    chk({tag, " lap_valid"}, lv, int'(e.lv));
    chk({tag, " lap_time"}, lt, enc_t(e.lt));
    chk({tag, " lap_count"}, lc, e.lc);
  endtask

  // Monitor: one prediction per edge; lap events are matched when the DUT flags them.
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) begin
      e0 = exp_q0.pop_front();
      check_inst("w0", e0, enc(min0, sec0, frac0), run0, done0, lv0, enc(lmin0, lsec0, lfrac0), lc0);
    end
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      check_inst("w1", e1, enc(min1, sec1, frac1), run1, done1, lv1, enc(lmin1, lsec1, lfrac1), lc1);
    end
    if (lv0) begin
      if (lapq0.size() == 0) chk("w0 lap event pending", lapq0.size(), 1);
      else chk("w0 lap event", enc(lmin0, lsec0, lfrac0), enc_t(lapq0.pop_front()));
    end
    if (lv1) begin
      if (lapq1.size() == 0) chk("w1 lap event pending", lapq1.size(), 1);
      else chk("w1 lap event", enc(lmin1, lsec1, lfrac1), enc_t(lapq1.pop_front()));
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_st[k] = MIdle; m_lt[k] = 0; m_lc[k] = 0; m_done[k] = 0; m_lv[k] = 0;
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("reset time", enc(min0, sec0, frac0), 0);
    chk("reset running", run0, 0);

    // Start then 25 ticks.
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(26);
    chk("run25 time", enc(min0, sec0, frac0), enc(0, 2, 5));
    chk("run25 running", run0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(4);
    chk("stop frozen", enc(min0, sec0, frac0), enc(0, 2, 6));
    chk("stop running", run0, 0);

    // Full-range up count: WRAP=0 holds at the maximum, WRAP=1 rolls over.
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1201);
    chk("w0 terminal time", enc(min0, sec0, frac0), enc(1, 59, 9));
    chk("w0 terminal done", done0, 1);
    chk("w0 terminal running", run0, 0);
    chk("w1 wrap time", enc(min1, sec1, frac1), 0);
    chk("w1 wrap done", done1, 1);
    chk("w1 wrap running", run1, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(5);
    chk("w0 start in done", run0, 0);

    // Down count from 0:1:0 to zero.
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0);
    idle(11);
    chk("down zero time", enc(min0, sec0, frac0), 0);
    chk("down zero done", done0, 1);
    chk("down zero running", run1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("clear lap_count", lc0, 0);

    // Laps: capture 0:0:7, then saturate the counter.
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(7);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("lap time", enc(lmin0, lsec0, lfrac0), enc(0, 0, 7));
    chk("lap valid", lv0, 1);
    chk("lap count1", lc0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle(1);
    end
    idle(1);
    chk("lap count sat", lc0, 15);
    chk("lap valid single", lv0, 0);

    // Clamped load, simultaneous start/stop, immediate done, reset with lap.
    cyc(0, 0, 1, 0, 0, 0, 0, 63, 100);
    idle(1);
    chk("clamp load", enc(min0, sec0, frac0), enc(1, 59, 0));
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(2);
    chk("start+stop stays paused", run0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0);
    idle(1);
    chk("start at zero down done", done0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("reset mid-run time", enc(min0, sec0, frac0), 0);
    chk("reset mid-run lap_valid", lv0, 0);

    // Randomized command mix.
    for (int i = 0; i < 4000; i++) begin
      bit nd;
      nd = dir;
      if ($urandom_range(0, 63) == 0) nd = ~dir;
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
          nd, $urandom_range(0, 63),
          ($urandom_range(0, 15) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 1));
    end

    idle(3);
    @(negedge clk);
    chk("w0 scoreboard drained", exp_q0.size(), 0);
    chk("w1 scoreboard drained", exp_q1.size(), 0);
    chk("w0 lap events drained", lapq0.size(), 0);
    chk("w1 lap events drained", lapq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
